// File: rtl/wallace_pkg.sv
// wallace_pkg: shared widths, partial-product row type and the 3:2 compressor function.
package wallace_pkg;
    localparam int OP_W = 4;
    localparam int PROD_W = 8;
    typedef logic [3:0][PROD_W-1:0] pp_rows_t;
    function automatic logic [2*PROD_W-1:0] csa32(input logic [PROD_W-1:0] x, input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
        return {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
    endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: PROD_W-wide 3:2 compressor; carry is already shifted to its weight, top carry dropped.
module csa_row import wallace_pkg::*; (
    input  logic [PROD_W-1:0] x,
    input  logic [PROD_W-1:0] y,
    input  logic [PROD_W-1:0] z,
    output logic [PROD_W-1:0] s,
    output logic [PROD_W-1:0] c
);
    assign {s, c} = csa32(x, y, z);
endmodule

// File: rtl/wallace_csa_pipe.sv
// wallace_csa_pipe: handshaked 4x4 partial-product + two-level CSA front end, redundant sum/carry out.
// WALLACE_CSA_PIPE_STAGE2_EN adds a register between CSA level 1 and level 2.
module wallace_csa_pipe import wallace_pkg::*; #(
    parameter int TAG_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_sum,
    output logic [PROD_W-1:0] out_carry,
    output logic [TAG_W-1:0]  out_tag
);
    pp_rows_t pp;
    logic [PROD_W-1:0] s1, c1, s2, c2, l2_x, l2_y, l2_z;
    logic [TAG_W-1:0] l2_tag;
    logic l2_valid, ld2;
    logic v2_q, v2_d;
    logic [PROD_W-1:0] sum_q, sum_d, carry_q, carry_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    always_comb begin
        for (int i = 0; i < 4; i++) pp[i] = {{OP_W{1'b0}}, in_a & {OP_W{in_b[i]}}} << i;
    end

    csa_row u_l1 (.x(pp[0]), .y(pp[1]), .z(pp[2]), .s(s1), .c(c1));
    csa_row u_l2 (.x(l2_x), .y(l2_y), .z(l2_z), .s(s2), .c(c2));

    // Output register loads when empty or when its word leaves this cycle.
    assign ld2 = !v2_q || out_ready;

`ifdef WALLACE_CSA_PIPE_STAGE2_EN
    logic v1_q, v1_d, ld1;
    logic [PROD_W-1:0] s1_q, s1_d, c1_q, c1_d, pp3_q, pp3_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    assign ld1 = !v1_q || ld2;
    assign in_ready = ld1;
    always_comb begin
        v1_d   = ld1 ? in_valid : v1_q;
        s1_d   = ld1 ? s1 : s1_q;
        c1_d   = ld1 ? c1 : c1_q;
        pp3_d  = ld1 ? pp[3] : pp3_q;
        tag1_d = ld1 ? in_tag : tag1_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            s1_q   <= '0;
            c1_q   <= '0;
            pp3_q  <= '0;
            tag1_q <= '0;
        end else begin
            v1_q   <= v1_d;
            s1_q   <= s1_d;
            c1_q   <= c1_d;
            pp3_q  <= pp3_d;
            tag1_q <= tag1_d;
        end
    end
    assign {l2_x, l2_y, l2_z, l2_tag, l2_valid} = {s1_q, c1_q, pp3_q, tag1_q, v1_q};
`else
    assign in_ready = ld2;
    assign {l2_x, l2_y, l2_z, l2_tag, l2_valid} = {s1, c1, pp[3], in_tag, in_valid};
`endif

    always_comb begin
        v2_d    = ld2 ? l2_valid : v2_q;
        sum_d   = ld2 ? s2 : sum_q;
        carry_d = ld2 ? c2 : carry_q;
        tag_d   = ld2 ? l2_tag : tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            tag_q   <= '0;
        end else begin
            v2_q    <= v2_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = v2_q;
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_tag   = tag_q;
endmodule

// File: tb/tb_wallace_csa_pipe.sv
// tb_wallace_csa_pipe: queue-based reference model with directed and random handshake traffic.
module tb_wallace_csa_pipe;
`ifdef WALLACE_CSA_PIPE_STAGE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int TAG_W = 2;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [3:0] in_a = '0, in_b = '0;
    logic [TAG_W-1:0] in_tag = '0, out_tag;
    logic [7:0] out_sum, out_carry;
    int n_chk = 0, n_pass = 0, n_in = 0, n_out = 0, cyc = 0;

    typedef struct {
        int prod;
        logic [TAG_W-1:0] tag;
        int cyc;
    } exp_t;
    exp_t q[$];
    logic pv = 1'b0;
    logic [7:0] ps, pc;
    logic [TAG_W-1:0] pt;

    always #5 clk = ~clk;

    wallace_csa_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] red();
        return (32'(out_sum) + 32'(out_carry)) & 32'hFF;
    endfunction

    // Model: queue of accepted words in order; occupancy bounds in_ready, age bounds out_valid.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            pv = 1'b0;
        end else begin
            if (pv) begin
                chk("hold_sum", 32'(out_sum), 32'(ps));
                chk("hold_carry", 32'(out_carry), 32'(pc));
                chk("hold_tag", 32'(out_tag), 32'(pt));
            end
            chk("m_in_ready", 32'(in_ready), 32'(q.size() < LAT || out_ready));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0 && cyc - q[0].cyc >= LAT));
            if (out_valid && q.size() > 0) begin
                chk("m_product", red(), 32'(q[0].prod));
                chk("m_tag", 32'(out_tag), 32'(q[0].tag));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                n_in++;
                q.push_back('{int'(in_a) * int'(in_b), in_tag, cyc});
            end
            pv = out_valid && !out_ready;
            ps = out_sum;
            pc = out_carry;
            pt = out_tag;
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [TAG_W-1:0] t, input logic r);
        in_valid = v;
        in_a = a;
        in_b = b;
        in_tag = t;
        out_ready = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int base_in, base_out;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_carry", 32'(out_carry), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        drive(1, 15, 15, 2, 1);
        cyc1();
        drive(0, 0, 0, 0, 1);
        repeat (LAT - 1) cyc1();
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 1);
        chk("single_sum", 32'(out_sum), 32'h69);
        chk("single_carry", 32'(out_carry), 32'h78);
        chk("single_tag", 32'(out_tag), 2);
        chk("single_product", red(), 225);
        cyc1();

        drive(1, 0, 13, 1, 1);
        cyc1();
        drive(0, 0, 0, 0, 1);
        repeat (LAT - 1) cyc1();
        @(negedge clk);
        chk("zero_valid", 32'(out_valid), 1);
        chk("zero_sum", 32'(out_sum), 0);
        chk("zero_carry", 32'(out_carry), 0);
        cyc1();

        base_in = n_in;
        base_out = n_out;
        for (int i = 0; i < 256; i++) begin
            drive(1, i[7:4], i[3:0], TAG_W'($urandom), 1);
            cyc1();
        end
        drive(0, 0, 0, 0, 1);
        repeat (LAT + 1) cyc1();
        chk("stream_in_fires", 32'(n_in - base_in), 256);
        chk("stream_out_fires", 32'(n_out - base_out), 256);

        drive(1, 9, 7, 3, 0);
        cyc1();
        drive(1, 1, 1, 0, 0);
        repeat (LAT - 1) cyc1();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_product", red(), 63);
            chk("bp_in_ready", 32'(in_ready), 0);
            cyc1();
        end
        base_out = n_out;
        drive(0, 0, 0, 0, 1);
        repeat (LAT + 2) cyc1();
        chk("bp_delivered", 32'(n_out - base_out), 32'(LAT));

        drive(1, 3, 5, 1, 0);
        cyc1();
        drive(0, 0, 0, 0, 0);
        repeat (LAT - 1) cyc1();
        drive(1, 12, 10, 2, 1);
        @(negedge clk);
        chk("sim_old_valid", 32'(out_valid), 1);
        chk("sim_old_product", red(), 15);
        chk("sim_in_ready", 32'(in_ready), 1);
        cyc1();
        drive(0, 0, 0, 0, 1);
        repeat (LAT - 1) cyc1();
        @(negedge clk);
        chk("sim_new_valid", 32'(out_valid), 1);
        chk("sim_new_product", red(), 120);
        chk("sim_new_tag", 32'(out_tag), 2);
        cyc1();

        drive(1, 6, 7, 1, 0);
        cyc1();
        drive(1, 2, 2, 0, 0);
        repeat (LAT) cyc1();
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_sum", 32'(out_sum), 0);
        chk("rst_mid_carry", 32'(out_carry), 0);
        chk("rst_mid_tag", 32'(out_tag), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        repeat (3) cyc1();
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 0);
        cyc1();

        for (int k = 0; k < 500; k++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), TAG_W'($urandom),
                  $urandom_range(0, 3) != 0);
            cyc1();
        end
        drive(0, 0, 0, 0, 1);
        repeat (LAT + 2) cyc1();
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 0);
        chk("drain_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
